pe_grid_sequencer: RTL

PE_GRID_SEQUENCER -- requirements
Module: pe_grid_sequencer

---
 rtl/pe_grid_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pe_grid_sequencer.sv
// Job sequencer for a systolic PE grid: skews input vectors onto the west edge, seeds the
// north edge with a per-job bias, and re-times grid results using a valid tag delay line.
module pe_grid_sequencer #(
    parameter int ROWS     = 9,
    parameter int COLS     = 1,
    parameter int LEN_W    = 8,
    parameter int GRID_LAT = 9
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [LEN_W-1:0]     i_len,
    input  logic [COLS*32-1:0]   i_bias,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [ROWS*9-1:0]    i_in_data,
    output logic [ROWS*9-1:0]    o_west_data,
    output logic [COLS*32-1:0]   o_north_data,
    input  logic [COLS*32-1:0]   i_grid_data,
    output logic                 o_out_valid,
    output logic [COLS*32-1:0]   o_out_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [1:0]           o_state
);

    localparam int PIPE   = ROWS + GRID_LAT;
    localparam int DCNT_W = $clog2(PIPE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    acc_cnt;
    logic [LEN_W:0]      acc_inc;
    logic [DCNT_W-1:0]   drain_cnt;
    logic                accept;
    logic                last_accept;
    logic                busy_nxt;
    logic [PIPE-1:0]     tag;

    // Handshake: a vector moves only on a cycle where i_in_valid and o_in_ready are both 1;
    // o_in_ready depends on state alone, never on i_in_valid.
    assign o_in_ready  = (state == FEED);
    assign o_state     = state;
    assign accept      = o_in_ready & i_in_valid;
    assign acc_inc     = {1'b0, acc_cnt} + {{LEN_W{1'b0}}, 1'b1};
    assign last_accept = accept && (acc_inc == {1'b0, len_q});
    assign busy_nxt    = (state_nxt == FEED) || (state_nxt == DRAIN);
    assign o_out_valid = tag[PIPE-1];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = (i_len != '0) ? FEED : DONE;
            FEED:    if (last_accept) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            len_q        <= '0;
            acc_cnt      <= '0;
            drain_cnt    <= '0;
            o_north_data <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            tag          <= '0;
            o_out_data   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && i_start) begin
                len_q   <= i_len;
                acc_cnt <= '0;
            end else if (accept) begin
                acc_cnt <= acc_inc[LEN_W-1:0];
            end
            // The drain window covers the full skew + grid latency of the last accepted vector.
            if (state == FEED && last_accept)
                drain_cnt <= DCNT_W'(PIPE - 1);
            else if (state == DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - DCNT_W'(1);
            o_busy <= busy_nxt;
            o_done <= (state_nxt == DONE);
            // The north register itself holds the bias sampled at job start.
            if (busy_nxt)
                o_north_data <= (state == IDLE) ? i_bias : o_north_data;
            else
                o_north_data <= '0;
            tag <= {tag[PIPE-2:0], accept};
            if (tag[PIPE-2])
                o_out_data <= i_grid_data;
        end
    end

    // Row r is delayed by r+1 registers; bubbles and non-FEED cycles push zeros.
    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        logic [8:0] line [r+1];
        logic [8:0] inject;

        assign inject = accept ? i_in_data[(ROWS-r)*9-1 -: 9] : 9'd0;

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                for (int k = 0; k <= r; k++) line[k] <= '0;
            end else begin
                line[0] <= inject;
                for (int k = 1; k <= r; k++) line[k] <= line[k-1];
            end
        end

        assign o_west_data[(ROWS-r)*9-1 -: 9] = line[r];
    end

endmodule
